// File: rtl/aes_round_key_store.sv
// aes_round_key_store: holds the cipher key plus NUM_ROUNDS expanded keys.
// Optional wipe engine (zeroize/zero_busy, ZERO state): define KEY_ZEROIZE_EN.
module aes_round_key_store #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             rk_valid,
    input  logic [KEY_W-1:0] rk_in,
    input  logic             rd_req,
    input  logic [3:0]       rd_round,
    input  logic             rd_decrypt,
    output logic             rd_valid,
    output logic [KEY_W-1:0] rd_key,
    output logic             rd_err,
    output logic             keys_ready,
    output logic             ovf_err
`ifdef KEY_ZEROIZE_EN
    ,
    input  logic             zeroize,
    output logic             zero_busy
`endif
);

    localparam int         NUM_ENT = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST    = 4'(NUM_ROUNDS);

`ifdef KEY_ZEROIZE_EN
    typedef enum logic [1:0] {IDLE, FILL, READY, ZERO} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, READY} state_t;
`endif

    state_t             state_q, state_d;
    logic [3:0]         widx_q, widx_d;
    logic               ready_q, ready_d;
    logic               ovf_q, ovf_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_err_q, rd_err_d;
    logic [KEY_W-1:0]   rd_key_q, rd_key_d;
    logic [KEY_W-1:0]   mem_q [NUM_ENT];

    logic               wr_en;
    logic [3:0]         wr_idx;
    logic [KEY_W-1:0]   wr_data;
    logic               load_ok;
    logic               rd_ok;
    logic [3:0]         rd_idx;

`ifdef KEY_ZEROIZE_EN
    logic [3:0]         zidx_q, zidx_d;
    logic               busy_q, busy_d;
`endif

    // Load/fill/wipe sequencing and the single storage write port
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        ready_d = ready_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        load_ok = load_start;
`ifdef KEY_ZEROIZE_EN
        zidx_d  = zidx_q;
        busy_d  = busy_q;
        if (zeroize || busy_q) begin
            load_ok = 1'b0;
        end
`endif
        if (load_ok) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            wr_data = key_in;
            state_d = FILL;
            widx_d  = 4'd1;
            ready_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (rk_valid) begin
            if (state_q == FILL) begin
                wr_en   = 1'b1;
                wr_idx  = widx_q;
                wr_data = rk_in;
                widx_d  = widx_q + 4'd1;
                if (widx_q == LAST) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
`ifdef KEY_ZEROIZE_EN
        if (state_q == ZERO) begin
            wr_en   = 1'b1;
            wr_idx  = zidx_q;
            wr_data = '0;
            zidx_d  = zidx_q + 4'd1;
            if (zidx_q == LAST) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end
        if (zeroize) begin
            wr_en   = 1'b0;
            state_d = ZERO;
            zidx_d  = '0;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            widx_d  = '0;
        end
`endif
    end

    // Read path: reject unless READY and index in range, else fetch entry
    always_comb begin
        rd_ok      = (state_q == READY) && (rd_round <= LAST);
        rd_idx     = '0;
        if (rd_ok) begin
            rd_idx = rd_decrypt ? (LAST - rd_round) : rd_round;
        end
        rd_valid_d = rd_req;
        rd_err_d   = rd_req && !rd_ok;
        rd_key_d   = rd_key_q;
        if (rd_req) begin
            rd_key_d = rd_ok ? mem_q[rd_idx] : '0;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            widx_q     <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_key_q   <= '0;
`ifdef KEY_ZEROIZE_EN
            zidx_q     <= '0;
            busy_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_key_q   <= rd_key_d;
`ifdef KEY_ZEROIZE_EN
            zidx_q     <= zidx_d;
            busy_q     <= busy_d;
`endif
        end
    end

`ifdef KEY_ZEROIZE_EN
    // Key storage, cleared by reset so no key survives a reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end
`else
    // Key storage, no reset so it maps onto plain RAM/flops
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end
`endif

    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign rd_key     = rd_key_q;
    assign keys_ready = ready_q;
    assign ovf_err    = ovf_q;
`ifdef KEY_ZEROIZE_EN
    assign zero_busy  = busy_q;
`endif

endmodule
